dualmem_fifo_ctrl: RTL and testbench

Streaming FIFO controller that wraps the team's dual-port RAM: port A is the write port, port B is the read port. It converts a valid/ready input stream into RAM writes and RAM reads back into a valid/ready output stream. It hides the RAM's one-cycle registered read latency behind a 2-entry output buffer, so throughput stays at one word per cycle.

---
 rtl/dualmem_fifo_ctrl.sv | 123 ++++++++++++
 tb/tb_dualmem_fifo_ctrl.sv | 398 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dualmem_fifo_ctrl.sv
// Streaming FIFO controller around a dual-port RAM (port A writes, port B reads).
// A 2-entry output buffer hides the RAM's registered read so one word per cycle flows.
module dualmem_fifo_ctrl #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clock,
    input  logic                  reset,

    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,

    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH:0]   count,

    output logic [DATA_WIDTH-1:0] ram_data_a,
    output logic [ADDR_WIDTH-1:0] ram_addr_a,
    output logic                  ram_we_a,
    output logic [DATA_WIDTH-1:0] ram_data_b,
    output logic [ADDR_WIDTH-1:0] ram_addr_b,
    output logic                  ram_we_b,
    input  logic [DATA_WIDTH-1:0] ram_q_b
);

    localparam logic [ADDR_WIDTH:0] FULL_COUNT = {1'b1, {ADDR_WIDTH{1'b0}}};

    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH:0]   ram_used;
    logic                  inflight;
    logic [DATA_WIDTH-1:0] ob_head;
    logic [DATA_WIDTH-1:0] ob_tail;
    logic [1:0]            ob_count;

    logic                  push;
    logic                  pop;
    logic                  issue;
    logic [2:0]            buf_load;
    logic [ADDR_WIDTH:0]   ram_used_next;
    logic [DATA_WIDTH-1:0] ob_head_next;
    logic [DATA_WIDTH-1:0] ob_tail_next;
    logic [1:0]            ob_count_next;
    logic [ADDR_WIDTH:0]   count_next;

    assign out_valid = (ob_count != 2'd0);
    assign out_data  = ob_head;

    assign push = in_valid & in_ready;
    assign pop  = out_valid & out_ready;

    // Buffer slots still spoken for after this cycle's pop; a new read may only
    // be issued if its data will find a free slot when it returns.
    assign buf_load = {1'b0, ob_count} + {2'b00, inflight} - {2'b00, pop};
    assign issue    = (ram_used != '0) && (buf_load <= 3'd1);

    assign ram_data_a = in_data;
    assign ram_addr_a = wr_ptr;
    assign ram_we_a   = push;
    assign ram_data_b = '0;
    assign ram_addr_b = rd_ptr;
    assign ram_we_b   = 1'b0;

    // NOTE: every output of this block is assigned a default first, so no latch is inferred.
    always_comb begin
        ob_head_next  = ob_head;
        ob_tail_next  = ob_tail;
        ob_count_next = ob_count;

        if (pop) begin
            ob_head_next  = ob_tail;
            ob_count_next = ob_count - 2'd1;
        end

        // Returning read data lands behind whatever survived the pop.
        if (inflight) begin
            if (ob_count_next == 2'd0) begin
                ob_head_next = ram_q_b;
            end else begin
                ob_tail_next = ram_q_b;
            end
            ob_count_next = ob_count_next + 2'd1;
        end

        ram_used_next = ram_used + {{ADDR_WIDTH{1'b0}}, push} - {{ADDR_WIDTH{1'b0}}, issue};
        count_next    = ram_used_next
                      + {{ADDR_WIDTH{1'b0}}, issue}
                      + {{(ADDR_WIDTH-1){1'b0}}, ob_count_next};
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            ram_used <= '0;
            inflight <= 1'b0;
            // NOTE: the buffer is cleared so out_data reads 0 after reset; the RAM array itself is never reset.
            ob_head  <= '0;
            ob_tail  <= '0;
            ob_count <= 2'd0;
            count    <= '0;
            in_ready <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (issue) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            ram_used <= ram_used_next;
            inflight <= issue;
            ob_head  <= ob_head_next;
            ob_tail  <= ob_tail_next;
            ob_count <= ob_count_next;
            count    <= count_next;
            in_ready <= (count_next < FULL_COUNT);
        end
    end

endmodule

// File: tb/tb_dualmem_fifo_ctrl.sv
// Self-checking bench for dualmem_fifo_ctrl: a behavioural RAM, a queue-based
// scoreboard monitor, and one task per scenario.
module tb_dualmem_fifo_ctrl;

    localparam int DW    = 16;
    localparam int AW    = 10;
    localparam int DEPTH = 1 << AW;

    logic          clock = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [AW:0]   count;
    logic [DW-1:0] ram_data_a;
    logic [AW-1:0] ram_addr_a;
    logic          ram_we_a;
    logic [DW-1:0] ram_data_b;
    logic [AW-1:0] ram_addr_b;
    logic          ram_we_b;
    logic [DW-1:0] ram_q_b;

    int n_cmp = 0;
    int n_err = 0;

    dualmem_fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clock      (clock),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .count      (count),
        .ram_data_a (ram_data_a),
        .ram_addr_a (ram_addr_a),
        .ram_we_a   (ram_we_a),
        .ram_data_b (ram_data_b),
        .ram_addr_b (ram_addr_b),
        .ram_we_b   (ram_we_b),
        .ram_q_b    (ram_q_b)
    );

    always #5 clock = ~clock;

    // Dual-port RAM with registered port-B read.
    logic [DW-1:0] mem [0:DEPTH-1];
    always @(posedge clock) begin
        if (ram_we_a) mem[ram_addr_a] <= ram_data_a;
        ram_q_b <= mem[ram_addr_b];
    end

    // Scoreboard: the FIFO's contents are simply the words accepted and not yet consumed.
    logic [DW-1:0] sb_q [$];
    logic [AW-1:0] sb_wr_idx = '0;
    logic          sb_after_reset = 1'b1;
    logic          sb_prev_stall = 1'b0;
    logic [DW-1:0] sb_prev_data = '0;
    logic          sb_exp_ready;

    always @(negedge clock) begin
        if (reset) begin
            sb_q.delete();
            sb_wr_idx      = '0;
            sb_after_reset = 1'b1;
            sb_prev_stall  = 1'b0;
        end else begin
            sb_exp_ready = sb_after_reset ? 1'b0 : (sb_q.size() < DEPTH);

            n_cmp++;
            if (in_ready !== sb_exp_ready) begin
                n_err++;
                $display("FAIL sb_in_ready t=%0t: got %b expected %b", $time, in_ready, sb_exp_ready);
            end
            n_cmp++;
            if (count !== (AW+1)'(sb_q.size())) begin
                n_err++;
                $display("FAIL sb_count t=%0t: got %0d expected %0d", $time, count, sb_q.size());
            end
            n_cmp++;
            if (ram_we_a !== (in_valid & sb_exp_ready) || (ram_we_a && ram_addr_a !== sb_wr_idx)) begin
                n_err++;
                $display("FAIL sb_ram_write t=%0t: got we=%b addr=%0d expected we=%b addr=%0d",
                         $time, ram_we_a, ram_addr_a, in_valid & sb_exp_ready, sb_wr_idx);
            end
            n_cmp++;
            if (ram_we_b !== 1'b0 || ram_data_b !== '0) begin
                n_err++;
                $display("FAIL sb_port_b_const t=%0t: got we=%b data=%h expected 0/0", $time, ram_we_b, ram_data_b);
            end
            n_cmp++;
            if ({1'b0, dut.ob_count} + {2'b00, dut.inflight} > 3'd2) begin
                n_err++;
                $display("FAIL sb_ob_bound t=%0t: got %0d expected <=2", $time, dut.ob_count + dut.inflight);
            end
            if (out_valid === 1'b1) begin
                n_cmp++;
                if (sb_q.size() == 0) begin
                    n_err++;
                    $display("FAIL sb_spurious_valid t=%0t: got out_valid=1 data=%h expected empty", $time, out_data);
                end else if (out_data !== sb_q[0]) begin
                    n_err++;
                    $display("FAIL sb_out_data t=%0t: got %h expected %h", $time, out_data, sb_q[0]);
                end
            end
            if (sb_prev_stall) begin
                n_cmp++;
                if (out_valid !== 1'b1 || out_data !== sb_prev_data) begin
                    n_err++;
                    $display("FAIL sb_stall_hold t=%0t: got v=%b d=%h expected v=1 d=%h",
                             $time, out_valid, out_data, sb_prev_data);
                end
            end

            if (in_valid && sb_exp_ready) begin
                sb_q.push_back(in_data);
                sb_wr_idx = sb_wr_idx + 1'b1;
            end
            if (out_valid === 1'b1 && out_ready && sb_q.size() > 0) begin
                void'(sb_q.pop_front());
            end
            sb_prev_stall  = (out_valid === 1'b1) && !out_ready;
            sb_prev_data   = out_data;
            sb_after_reset = 1'b0;
        end
    end

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        next_cycle();
        @(negedge clock);
        n_cmp++;
        if ({in_ready, out_valid, ram_we_a, ram_we_b} !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_flags: got in_ready=%b out_valid=%b we_a=%b we_b=%b expected all 0",
                     in_ready, out_valid, ram_we_a, ram_we_b);
        end
        n_cmp++;
        if (out_data !== '0 || count !== '0 || ram_data_b !== '0) begin
            n_err++;
            $display("FAIL reset_values: got out_data=%h count=%0d data_b=%h expected 0", out_data, count, ram_data_b);
        end
        n_cmp++;
        if (ram_addr_a !== '0 || ram_addr_b !== '0) begin
            n_err++;
            $display("FAIL reset_addrs: got a=%0d b=%0d expected 0/0", ram_addr_a, ram_addr_b);
        end
        next_cycle();
        reset = 1'b0;
        @(negedge clock);
        n_cmp++;
        if (in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL reset_ready_low: got %b expected 0", in_ready);
        end
        next_cycle();
        @(negedge clock);
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_ready_rise: got %b expected 1", in_ready);
        end
        next_cycle();
    endtask

    // Push one word into an empty FIFO at the current cycle and follow it out.
    task automatic push_and_expect(input logic [DW-1:0] word);
        logic [AW:0] exp_count;
        in_valid  = 1'b1;
        in_data   = word;
        out_ready = 1'b1;
        @(negedge clock);
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL single_accept: got in_ready=%b expected 1", in_ready);
        end
        next_cycle();
        in_valid = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clock);
            exp_count = (k == 4) ? '0 : (AW+1)'(1);
            n_cmp++;
            if (out_valid !== (k == 3)) begin
                n_err++;
                $display("FAIL single_valid_t%0d: got %b expected %b", k, out_valid, k == 3);
            end
            n_cmp++;
            if (count !== exp_count) begin
                n_err++;
                $display("FAIL single_count_t%0d: got %0d expected %0d", k, count, exp_count);
            end
            if (k == 3) begin
                n_cmp++;
                if (out_data !== word) begin
                    n_err++;
                    $display("FAIL single_data: got %h expected %h", out_data, word);
                end
            end
            next_cycle();
        end
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clock);
            if (count == '0 && !out_valid) break;
            next_cycle();
        end
        n_cmp++;
        if (count !== '0) begin
            n_err++;
            $display("FAIL drain_timeout: got count=%0d expected 0", count);
        end
        next_cycle();
        out_ready = 1'b0;
    endtask

    task automatic test_streaming();
        int sent = 0;
        int recv = 0;
        int gaps = 0;
        int max_count = 0;
        logic started = 1'b0;
        in_valid  = 1'b1;
        in_data   = '0;
        out_ready = 1'b1;
        for (int c = 0; c < 6000 && recv < 4096; c++) begin
            @(negedge clock);
            if (in_valid && in_ready) sent++;
            if (int'(count) > max_count) max_count = int'(count);
            if (out_valid) begin
                started = 1'b1;
                n_cmp++;
                if (out_data !== DW'(recv)) begin
                    n_err++;
                    $display("FAIL stream_order: got %h expected %h", out_data, DW'(recv));
                end
                recv++;
            end else if (started) begin
                gaps++;
            end
            next_cycle();
            if (sent < 4096) in_data = DW'(sent);
            else             in_valid = 1'b0;
        end
        n_cmp++;
        if (recv != 4096) begin
            n_err++;
            $display("FAIL stream_recv: got %0d expected 4096", recv);
        end
        n_cmp++;
        if (gaps != 0) begin
            n_err++;
            $display("FAIL stream_gaps: got %0d expected 0", gaps);
        end
        n_cmp++;
        if (max_count > 3) begin
            n_err++;
            $display("FAIL stream_max_count: got %0d expected <=3", max_count);
        end
        drain();
    endtask

    task automatic test_fill_and_full_pushpop();
        int accepted = 0;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        for (int c = 0; c < 1026; c++) begin
            in_data = DW'($urandom);
            @(negedge clock);
            if (in_ready) accepted++;
            next_cycle();
        end
        in_valid = 1'b0;
        @(negedge clock);
        n_cmp++;
        if (accepted != DEPTH) begin
            n_err++;
            $display("FAIL fill_accepted: got %0d expected %0d", accepted, DEPTH);
        end
        n_cmp++;
        if (in_ready !== 1'b0 || count !== (AW+1)'(DEPTH)) begin
            n_err++;
            $display("FAIL fill_full: got in_ready=%b count=%0d expected 0/%0d", in_ready, count, DEPTH);
        end
        next_cycle();
        // Push and pop presented together while full.
        in_valid  = 1'b1;
        in_data   = 16'hA5A5;
        out_ready = 1'b1;
        @(negedge clock);
        n_cmp++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            n_err++;
            $display("FAIL full_pushpop: got in_ready=%b out_valid=%b expected 0/1", in_ready, out_valid);
        end
        next_cycle();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(negedge clock);
        n_cmp++;
        if (count !== (AW+1)'(DEPTH - 1) || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL full_after_pop: got count=%0d in_ready=%b expected %0d/1", count, in_ready, DEPTH - 1);
        end
        next_cycle();
        drain();
    endtask

    task automatic test_mid_reset();
        int pushed = 0;
        int popped = 0;
        in_valid  = 1'b1;
        in_data   = 16'h0100;
        out_ready = 1'b0;
        for (int c = 0; c < 50 && pushed < 10; c++) begin
            @(negedge clock);
            if (in_ready) pushed++;
            next_cycle();
            in_data = 16'h0100 + DW'(pushed);
        end
        in_valid = 1'b0;
        repeat (4) next_cycle();
        out_ready = 1'b1;
        for (int c = 0; c < 50 && popped < 3; c++) begin
            @(negedge clock);
            if (out_valid) popped++;
            next_cycle();
        end
        n_cmp++;
        if (pushed != 10 || popped != 3) begin
            n_err++;
            $display("FAIL midrst_setup: got pushed=%0d popped=%0d expected 10/3", pushed, popped);
        end
        n_cmp++;
        if (dut.inflight !== 1'b1) begin
            n_err++;
            $display("FAIL midrst_inflight: got %b expected 1", dut.inflight);
        end
        out_ready = 1'b0;
        reset     = 1'b1;
        next_cycle();
        reset = 1'b0;
        @(negedge clock);
        n_cmp++;
        if (count !== '0 || out_valid !== 1'b0 || in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL midrst_cleared: got count=%0d out_valid=%b in_ready=%b expected 0/0/0",
                     count, out_valid, in_ready);
        end
        next_cycle();
        @(negedge clock);
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL midrst_ready: got %b expected 1", in_ready);
        end
        next_cycle();
        push_and_expect(16'hBEEF);
    endtask

    task automatic test_backpressure();
        for (int c = 0; c < 20000; c++) begin
            in_valid  = ($urandom_range(9) < 7);
            in_data   = DW'($urandom);
            out_ready = $urandom_range(1);
            next_cycle();
        end
        drain();
    endtask

    initial begin
        test_reset();
        push_and_expect(16'h1234);
        test_streaming();
        test_fill_and_full_pushpop();
        test_mid_reset();
        test_backpressure();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
